// File: rtl/uart_globals_pkg.sv
// Shared UART types: frame-format encodings, tx FSM states and small frame-timing helpers.
package uart_globals_pkg;

  typedef enum logic [3:0] {
    FIVE_BIT  = 4'd5,
    SIX_BIT   = 4'd6,
    SEVEN_BIT = 4'd7,
    EIGHT_BIT = 4'd8,
    NINE_BIT  = 4'd9
  } uart_type_e;

  typedef enum logic {EVEN_PARITY = 1'b0, ODD_PARITY = 1'b1} parity_e;

  typedef enum logic [1:0] {
    STOP_BIT_ONE_HALF = 2'd0,
    STOP_BIT_ONE      = 2'd1,
    STOP_BIT_TWO      = 2'd2
  } stop_bit_e;

  typedef enum logic {LSB_FIRST = 1'b0, MSB_FIRST = 1'b1} shift_direction_e;

  typedef enum logic [4:0] {
    OVS_2  = 5'd2,  OVS_4  = 5'd4,  OVS_6  = 5'd6,  OVS_8  = 5'd8,
    OVS_10 = 5'd10, OVS_12 = 5'd12, OVS_14 = 5'd14, OVS_16 = 5'd16
  } oversampling_e;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_e;

  // Length of the stop period in oversample ticks.
  function automatic int stop_ticks(input logic [1:0] sb, input logic [4:0] ovs);
    int o;
    o = int'(ovs);
    case (sb)
      STOP_BIT_ONE_HALF: stop_ticks = o + o / 2;
      STOP_BIT_TWO:      stop_ticks = 2 * o;
      default:           stop_ticks = o;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Divisor counter: one tick every div cycles (0 behaves as 1); clear holds it at phase zero.
module uart_baud_tick_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 pclk,
  input  logic                 areset,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt, last;

  assign last = (div == '0) ? '0 : div - 1'b1;
  assign tick = !clear && (cnt == last);

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset)            cnt <= '0;
    else if (clear || tick) cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: latches one character plus frame format per handshake and
// serialises start, data, optional parity and stop bits on tx.
module uart_tx_serializer
  import uart_globals_pkg::*;
#(
  parameter int CHAR_LENGTH      = 8,
  parameter int DIV_WIDTH        = 16,
  parameter int MAX_OVERSAMPLING = 16
) (
  input  logic                   pclk,
  input  logic                   areset,
  input  logic [DIV_WIDTH-1:0]   cfg_baud_div,
  input  logic [3:0]             cfg_data_bits,
  input  logic                   cfg_parity_en,
  input  logic                   cfg_parity,
  input  logic [1:0]             cfg_stop_bits,
  input  logic [4:0]             cfg_oversampling,
  input  logic                   cfg_msb_first,
  input  logic                   tx_valid,
  input  logic [CHAR_LENGTH-1:0] tx_data,
  output logic                   tx_ready,
  output logic                   tx,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   cfg_err
);

  localparam int BCW = $clog2(MAX_OVERSAMPLING * 2 + 1);

  uart_tx_state_e         state, state_nxt;
  logic [DIV_WIDTH-1:0]   div_q;
  logic [3:0]             nbits_q, bit_idx;
  logic                   par_en_q, par_bit;
  logic [1:0]             stop_q;
  logic [4:0]             ovs_q;
  logic [CHAR_LENGTH-1:0] sr, mask, data_m, data_rev, data_sh;
  logic [BCW-1:0]         bit_cnt, bit_len;
  logic                   tick, bit_end, accept, cfg_ok, tick_clear;

  assign accept   = tx_valid && tx_ready;
  assign tx_ready = (state == IDLE) && !cfg_err;
  assign busy     = !tx_ready;

  assign cfg_ok = (cfg_data_bits >= 4'd5) && (int'(cfg_data_bits) <= CHAR_LENGTH)
               && !cfg_oversampling[0] && (cfg_oversampling >= 5'd2)
               && (int'(cfg_oversampling) <= MAX_OVERSAMPLING)
               && (cfg_stop_bits != 2'd3);

  // MSB-first frames are bit-reversed at accept so the datapath always shifts right.
  always_comb begin
    mask     = '0;
    data_rev = '0;
    for (int i = 0; i < CHAR_LENGTH; i++) mask[i] = (i < int'(cfg_data_bits));
    data_m = tx_data & mask;
    for (int i = 0; i < CHAR_LENGTH; i++) data_rev[i] = data_m[CHAR_LENGTH-1-i];
    data_sh = cfg_msb_first ? (data_rev >> (CHAR_LENGTH - int'(cfg_data_bits))) : data_m;
  end

  assign tick_clear = (state == IDLE);

  uart_baud_tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .pclk  (pclk),
    .areset(areset),
    .clear (tick_clear),
    .div   (div_q),
    .tick  (tick)
  );

  always_comb begin
    bit_len = BCW'(int'(ovs_q) - 1);
    if (state == STOP) bit_len = BCW'(stop_ticks(stop_q, ovs_q) - 1);
  end
  assign bit_end = tick && (bit_cnt == bit_len);

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && cfg_ok) state_nxt = START;
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && bit_idx == nbits_q - 4'd1) state_nxt = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_end) state_nxt = STOP;
      STOP:    if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = sr[0];
      PARITY:  tx = par_bit;
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      div_q      <= '0;
      nbits_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit    <= 1'b0;
      stop_q     <= '0;
      ovs_q      <= '0;
      sr         <= '0;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      frame_done <= (state == STOP) && bit_end;
      cfg_err    <= accept && !cfg_ok;
      if (accept) begin
        div_q    <= cfg_baud_div;
        nbits_q  <= cfg_data_bits;
        par_en_q <= cfg_parity_en;
        par_bit  <= (^data_m) ^ cfg_parity;
        stop_q   <= cfg_stop_bits;
        ovs_q    <= cfg_oversampling;
        sr       <= data_sh;
      end
      if (state == IDLE)  bit_cnt <= '0;
      else if (tick)      bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
      if (state == IDLE) bit_idx <= '0;
      else if (state == DATA && bit_end) begin
        bit_idx <= bit_idx + 4'd1;
        sr      <= sr >> 1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: frames are checked cycle by cycle against hand-built bit sequences.
module tb_uart_tx_serializer;
  logic        pclk = 1'b0;
  logic        areset = 1'b0;
  logic [15:0] cfg_baud_div = 16'd1;
  logic [3:0]  cfg_data_bits = 4'd8;
  logic        cfg_parity_en = 1'b0;
  logic        cfg_parity = 1'b0;
  logic [1:0]  cfg_stop_bits = 2'd1;
  logic [4:0]  cfg_oversampling = 5'd4;
  logic        cfg_msb_first = 1'b0;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_ready, tx, busy, frame_done, cfg_err;
  int          checks = 0;
  int          errors = 0;

  uart_tx_serializer dut (
    .pclk(pclk), .areset(areset), .cfg_baud_div(cfg_baud_div), .cfg_data_bits(cfg_data_bits),
    .cfg_parity_en(cfg_parity_en), .cfg_parity(cfg_parity), .cfg_stop_bits(cfg_stop_bits),
    .cfg_oversampling(cfg_oversampling), .cfg_msb_first(cfg_msb_first), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .tx(tx), .busy(busy), .frame_done(frame_done),
    .cfg_err(cfg_err)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [3:0] nb, input logic pe, input logic par,
                      input logic [1:0] sb, input logic [4:0] ovs, input logic msb,
                      input logic [15:0] div, input bit hold);
    @(negedge pclk);
    tx_data = d; cfg_data_bits = nb; cfg_parity_en = pe; cfg_parity = par;
    cfg_stop_bits = sb; cfg_oversampling = ovs; cfg_msb_first = msb; cfg_baud_div = div;
    tx_valid = 1'b1;
    @(posedge pclk);
    #1;
    if (!hold) tx_valid = 1'b0;
  endtask

  // bits[0] is the start bit, sent first; each bit lasts cyc cycles, then stop_cyc high cycles.
  task automatic check_frame(input string tag, input logic [15:0] bits, input int nb,
                             input int cyc, input int stop_cyc);
    for (int k = 0; k < nb; k++)
      for (int c = 0; c < cyc; c++) begin
        @(negedge pclk);
        chk(tag, tx, bits[k]);
      end
    for (int c = 0; c < stop_cyc; c++) begin
      @(negedge pclk);
      chk({tag, "_stop"}, {tx, busy}, 2'b11);
    end
  endtask

  task automatic check_end(input string tag);
    @(negedge pclk);
    chk({tag, "_done"}, {frame_done, tx_ready, tx}, 3'b111);
    @(negedge pclk);
    chk({tag, "_done_clr"}, frame_done, 1'b0);
  endtask

  task automatic check_illegal(input string tag, input logic [3:0] nb, input logic [4:0] ovs,
                               input logic [1:0] sb);
    send(8'h5A, nb, 1'b0, 1'b0, sb, ovs, 1'b0, 16'd1, 1'b0);
    @(negedge pclk);
    chk({tag, "_err"}, {cfg_err, tx, tx_ready, busy}, 4'b1101);
    @(negedge pclk);
    chk({tag, "_after"}, {cfg_err, tx, tx_ready, busy}, 4'b0110);
    @(negedge pclk);
    chk({tag, "_idle"}, {cfg_err, tx}, 2'b01);
  endtask

  initial begin
    #12;
    chk("reset", {tx, tx_ready, busy, frame_done, cfg_err}, 5'b11000);
    @(negedge pclk);
    areset = 1'b1;
    @(negedge pclk);
    chk("idle", {tx, tx_ready, busy}, 3'b110);

    // 8N1 0xA5 LSB-first, div 1, ovs 4
    send(8'hA5, 4'd8, 1'b0, 1'b0, 2'd1, 5'd4, 1'b0, 16'd1, 1'b0);
    check_frame("t1", {7'd0, 8'hA5, 1'b0}, 9, 4, 4);
    check_end("t1");

    // 7 bits odd parity MSB-first 0x55, div 3, ovs 2
    send(8'h55, 4'd7, 1'b1, 1'b1, 2'd1, 5'd2, 1'b1, 16'd3, 1'b0);
    check_frame("t2", 16'h01AA, 9, 6, 6);
    check_end("t2");

    // 5 bits, 1.5 stop, ovs 8, div 2
    send(8'h1F, 4'd5, 1'b0, 1'b0, 2'd0, 5'd8, 1'b0, 16'd2, 1'b0);
    check_frame("t3", 16'h003E, 6, 16, 24);
    check_end("t3");

    // back-to-back 8N2 with tx_valid held; second frame has new data and ovs
    send(8'h3C, 4'd8, 1'b0, 1'b0, 2'd2, 5'd2, 1'b0, 16'd1, 1'b1);
    tx_data = 8'hC3; cfg_oversampling = 5'd4;
    check_frame("t4a", {7'd0, 8'h3C, 1'b0}, 9, 2, 4);
    @(negedge pclk);
    chk("t4_gap", {tx, tx_ready, frame_done}, 3'b111);
    @(posedge pclk);
    #1 tx_valid = 1'b0;
    check_frame("t4b", {7'd0, 8'hC3, 1'b0}, 9, 4, 8);
    check_end("t4b");

    // illegal configurations
    check_illegal("t5_bits", 4'd4, 5'd4, 2'd1);
    check_illegal("t5_ovs", 4'd8, 5'd3, 2'd1);
    check_illegal("t5_stop", 4'd8, 5'd4, 2'd3);

    // reset mid-DATA then a clean frame
    send(8'hA5, 4'd8, 1'b0, 1'b0, 2'd1, 5'd4, 1'b0, 16'd1, 1'b0);
    repeat (10) @(negedge pclk);
    chk("t6_in_data", {tx, busy}, 2'b01);
    areset = 1'b0;
    #1;
    chk("t6_reset", {tx, tx_ready, busy, frame_done}, 4'b1100);
    @(negedge pclk);
    areset = 1'b1;
    send(8'hA5, 4'd8, 1'b0, 1'b0, 2'd1, 5'd4, 1'b0, 16'd1, 1'b0);
    check_frame("t6", {7'd0, 8'hA5, 1'b0}, 9, 4, 4);
    check_end("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
